// File: rtl/mfp_bot_upd_resp.sv
// CPU-side responder for the Rojobot update handshake: snapshots bot_info, raises bot_irq, returns bot_int_ack.
// Optional build macro MFP_BOT_UPD_CNT_EN adds a 16-bit update counter readable at STATUS[31:16].
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for bot_update_sync
// S_CAPTURE  | one cycle: snapshot bot_info, raise bot_irq, load timeout
// S_WAIT_CPU | interrupt pending, waiting for CPU ack or timeout
// S_ACK      | one cycle: bot_int_ack high, bot_irq dropped
// S_DRAIN    | waiting for bot_update_sync to clear before re-arming
module mfp_bot_upd_resp #(
  parameter int         ACK_TIMEOUT = 1000000,
  parameter logic [7:0] CTRL_RST    = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] bot_info,
  input  logic        bot_update_sync,
  output logic        bot_int_ack,
  output logic [7:0]  bot_ctrl,
  output logic        bot_irq,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_WAIT_CPU,
    S_ACK,
    S_DRAIN
  } state_t;

  state_t         state, state_nx;
  logic [31:0]    snapshot;
  logic           stale;
  logic [TW-1:0]  tmo_cnt;
  logic           tmo_hit, tmo_exp;
  logic           ack_wr, ack_req, ctrl_wr, rd_en;
  logic [15:0]    upd_cnt_rd;
  logic [31:0]    rd_mux;

  assign ack_wr  = sel & we & (addr == 2'd3);
  assign ack_req = ack_wr & wdata[0];
  assign ctrl_wr = sel & we & (addr == 2'd1);
  assign rd_en   = sel & ~we;

  // Down-counter reaches zero on the ACK_TIMEOUT-th cycle spent in S_WAIT_CPU.
  assign tmo_hit = (ACK_TIMEOUT != 0) && (tmo_cnt == '0);

  always_comb begin
    state_nx = state;
    tmo_exp  = 1'b0;
    case (state)
      S_IDLE:     if (bot_update_sync) state_nx = S_CAPTURE;
      S_CAPTURE:  state_nx = S_WAIT_CPU;
      S_WAIT_CPU: begin
        if (ack_req) begin
          state_nx = S_ACK;
        end else if (tmo_hit) begin
          state_nx = S_ACK;
          tmo_exp  = 1'b1;
        end
      end
      S_ACK:      state_nx = S_DRAIN;
      S_DRAIN:    if (!bot_update_sync) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0:    rd_mux = snapshot;
      2'd1:    rd_mux = {24'h0, bot_ctrl};
      2'd2:    rd_mux = {upd_cnt_rd, 14'h0, stale, (state == S_WAIT_CPU)};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bot_int_ack <= 1'b0;
      bot_irq     <= 1'b0;
      bot_ctrl    <= CTRL_RST;
      rdata       <= '0;
      snapshot    <= '0;
      stale       <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      state       <= state_nx;
      // Registered decode of the next state keeps the ack a clean single-cycle pulse.
      bot_int_ack <= (state_nx == S_ACK);

      if (state == S_CAPTURE) begin
        snapshot <= bot_info;
        bot_irq  <= 1'b1;
        tmo_cnt  <= TMO_LOAD;
      end else if (state == S_WAIT_CPU && tmo_cnt != '0) begin
        tmo_cnt  <= tmo_cnt - TW'(1);
      end

      if (state == S_ACK) bot_irq <= 1'b0;

      if (ctrl_wr) bot_ctrl <= wdata[7:0];

      // A timeout in the same cycle as a clear leaves stale set: the newer event wins.
      if (ack_wr && wdata[1]) stale <= 1'b0;
      if (tmo_exp)            stale <= 1'b1;

      if (rd_en) rdata <= rd_mux;
    end
  end

`ifdef MFP_BOT_UPD_CNT_EN
  logic [15:0] upd_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_cnt <= '0;
    end else if (ack_wr && wdata[2]) begin
      upd_cnt <= '0;
    end else if (state == S_CAPTURE) begin
      upd_cnt <= upd_cnt + 16'd1;
    end
  end

  assign upd_cnt_rd = upd_cnt;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:8]};
`else
  assign upd_cnt_rd = '0;

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata[31:8], wdata[2]};
`endif

endmodule

// File: doc/mfp_bot_upd_resp.md
Name: mfp_bot_upd_resp

Overview:
- CPU-side responder for the Rojobot update handshake.
- Watches the level-type update-sync flag, snapshots the 32-bit bot info word and raises an interrupt request.
- Pulses the interrupt-ack back to the handshake flip-flop once the CPU acknowledges through a small register port.
- Also holds the motor-control register driven to the bot.
- Sits in mfp_sys next to the GPIO register slaves, on the 50 MHz system clock.

Parameters:
- ACK_TIMEOUT, 1000000, cycles in WAIT_CPU before auto-acknowledge; 0 disables the timeout.
- CTRL_RST, 8'h00, reset value of the motor-control register.

Ports:
- clk  input  1  system clock (50 MHz domain).
- reset  input  1  synchronous, active-high reset.
- bot_info  input  32  {LocX, LocY, Sensors, BotInfo} from the bot.
- bot_update_sync  input  1  level flag; high = update pending.
- bot_int_ack  output  1  one-cycle ack pulse to the handshake flip-flop.
- bot_ctrl  output  8  motor-control byte to the bot.
- bot_irq  output  1  interrupt request to the CPU, level.
- sel  input  1  register access strobe, one cycle.
- we  input  1  1 = write, 0 = read; qualified by sel.
- addr  input  2  register index.
- wdata  input  32  write data.
- rdata  output  32  read data, registered.

Behaviour:
- Interface fixed: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: bot_int_ack=0, bot_irq=0, bot_ctrl=CTRL_RST, rdata=0, snapshot=0, stale=0, state=IDLE.
- Register map:
  - 0 INFO (RO): snapshot.
  - 1 CTRL (RW): [7:0] bot_ctrl; upper bits read 0.
  - 2 STATUS (RO): bit0 pending (state==WAIT_CPU), bit1 stale, [31:16] update count (optional feature).
  - 3 ACK (WO): write with wdata[0]=1 acknowledges. Any write to 3 also clears stale when wdata[1]=1. Reads of 3 return 0.
- Reads: sel&~we latches rdata on the next clock edge (1-cycle latency). rdata holds its value otherwise.
- Writes to CTRL take effect on bot_ctrl at the next edge. They are allowed in any state.
- FSM:
  - IDLE: bot_update_sync=1 -> CAPTURE.
  - CAPTURE (1 cycle): snapshot<=bot_info; bot_irq<=1; timeout counter<=0; -> WAIT_CPU.
  - WAIT_CPU:
    - ACK write with wdata[0]=1 -> ACK.
    - Else, if ACK_TIMEOUT!=0 and counter==ACK_TIMEOUT-1 -> stale<=1 and -> ACK.
    - Counter increments every cycle and saturates.
  - ACK (1 cycle): bot_int_ack=1; bot_irq<=0; -> DRAIN.
  - DRAIN: wait until bot_update_sync==0, then -> IDLE. This prevents recapturing the same, not-yet-cleared flag.
- Latency:
  - sync rising to bot_irq high: 2 cycles.
  - ACK write to bot_int_ack pulse: 1 cycle after the write edge.
  - bot_int_ack is never asserted for more than 1 consecutive cycle.
- Boundary cases:
  - ACK write in IDLE, CAPTURE, ACK or DRAIN: ignored, no pulse.
  - ACK write and timeout expiry in the same cycle: treated as CPU ack; stale not set.
  - Snapshot is frozen from CAPTURE until the next CAPTURE. INFO reads in any state return it.
  - bot_update_sync stays high through DRAIN longer than expected: remain in DRAIN with no further pulses.
  - Reset mid-operation (any state): return to IDLE. bot_irq and bot_int_ack go to 0 in the same edge. bot_ctrl returns to CTRL_RST.
  - Read and ACK in the same cycle are impossible (single strobe). Back-to-back accesses on consecutive cycles are all honoured.

Optional Feature:
- Macro: MFP_BOT_UPD_CNT_EN.
- Defined:
  - 16-bit counter increments on each CAPTURE and wraps FFFF->0000.
  - Readable at STATUS[31:16].
  - Cleared by reset or by an ACK write with wdata[2]=1.
- Undefined: no counter logic; STATUS[31:16] reads 0; wdata[2] ignored.

Test Plan:
- Capture: bot_info=32'h12345678, raise sync -> bot_irq=1 two cycles later; INFO read returns 12345678; STATUS bit0=1.
- Ack handshake: in WAIT_CPU write ACK=1 -> exactly one bot_int_ack cycle; bot_irq=0. Drop sync 1 cycle after the ack -> IDLE. Raise sync again with bot_info=32'hAABBCCDD -> new capture.
- Spurious ack: write ACK=1 while IDLE -> no pulse; STATUS=0.
- Timeout: ACK_TIMEOUT=8, no CPU ack -> pulse on cycle 8 of WAIT_CPU; STATUS bit1=1. Write ACK with wdata=2 -> stale cleared.
- Control and reset: write CTRL=32'h000000A5 -> bot_ctrl=A5 next cycle. Assert reset in WAIT_CPU -> bot_irq=0, bot_ctrl=00, state IDLE. Sync still high after reset -> recaptured.
- Counter (MFP_BOT_UPD_CNT_EN defined): 3 full handshakes -> STATUS[31:16]=0003. ACK write wdata=4 -> reads 0000.
